// File: rtl/connect_n_pkg.sv
// Shared types for the connect-N game core: cell codes, FSM states and scan directions.
package connect_n_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    PA    = 2'b01,
    PB    = 2'b10
  } cell_t;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    H,
    V,
    D1,
    D2
  } dir_t;

  function automatic cell_t player_cell(input logic p);
    return p ? PB : PA;
  endfunction

endpackage

// File: rtl/connect_n_run.sv
// Combinational run-length test through one origin cell along a single direction.
module connect_n_run
  import connect_n_pkg::*;
#(
  parameter int unsigned ROWS    = 6,
  parameter int unsigned COLS    = 7,
  parameter int unsigned WIN_LEN = 4
) (
  input  logic [2*ROWS*COLS-1:0]  board,
  input  logic [$clog2(ROWS)-1:0] origin_row,
  input  logic [$clog2(COLS)-1:0] origin_col,
  input  dir_t                    dir,
  input  cell_t                   colour,
  output logic                    hit
);

  // Matching cells beyond the origin along (dr, dc); stops at the first mismatch or grid edge.
  function automatic int side_len(input logic [2*ROWS*COLS-1:0] b, input int r0, input int c0,
                                  input int dr, input int dc, input logic [1:0] col);
    int n;
    bit run_on;
    int r;
    int c;
    n      = 0;
    run_on = 1'b1;
    for (int k = 1; k < int'(WIN_LEN); k++) begin
      r = r0 + k * dr;
      c = c0 + k * dc;
      if (r < 0 || r >= int'(ROWS) || c < 0 || c >= int'(COLS)) begin
        run_on = 1'b0;
      end else if (run_on && b[2*(r*int'(COLS)+c) +: 2] == col) begin
        n++;
      end else begin
        run_on = 1'b0;
      end
    end
    return n;
  endfunction

  int dr;
  int dc;
  int run_len;

  always_comb begin
    dr = 0;
    dc = 1;
    case (dir)
      H:       begin dr = 0; dc = 1;  end
      V:       begin dr = 1; dc = 0;  end
      D1:      begin dr = 1; dc = 1;  end
      D2:      begin dr = 1; dc = -1; end
      default: begin dr = 0; dc = 1;  end
    endcase
    run_len = 1 + side_len(board, int'(origin_row), int'(origin_col), dr, dc, colour)
                + side_len(board, int'(origin_row), int'(origin_col), -dr, -dc, colour);
    hit = (run_len >= int'(WIN_LEN));
  end

endmodule

// File: rtl/connect_n_core.sv
// Connect-N game core: board state, cursor, turn order and four-cycle win/full detection.
module connect_n_core
  import connect_n_pkg::*;
#(
  parameter int unsigned ROWS         = 6,
  parameter int unsigned COLS         = 7,
  parameter int unsigned WIN_LEN      = 4,
  parameter int unsigned FIRST_PLAYER = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           left,
  input  logic                           right,
  input  logic                           put,
  input  logic                           new_game,
  output logic [2*ROWS*COLS-1:0]         board,
  output logic [$clog2(COLS)-1:0]        cursor,
  output logic                           player,
  output logic                           busy,
  output logic                           invalid_move,
  output logic                           win_a,
  output logic                           win_b,
  output logic                           full_panel,
  output logic [$clog2(ROWS*COLS+1)-1:0] move_count
);

  localparam int unsigned NB = 2 * ROWS * COLS;
  localparam int unsigned RW = $clog2(ROWS);
  localparam int unsigned CW = $clog2(COLS);
  localparam int unsigned HW = $clog2(ROWS + 1);
  localparam int unsigned MW = $clog2(ROWS * COLS + 1);

  localparam logic [HW-1:0] RowsH   = HW'(ROWS);
  localparam logic [MW-1:0] CellsM  = MW'(ROWS * COLS);
  localparam logic [CW-1:0] ColMax  = CW'(COLS - 1);
  localparam logic [CW-1:0] CurInit = CW'(COLS / 2);
  localparam logic          FirstP  = (FIRST_PLAYER != 0);

  state_t        state_q, state_d;
  dir_t          dir_q, dir_d;
  logic [NB-1:0] board_q, board_d;
  logic [HW-1:0] height_q [COLS];
  logic [HW-1:0] height_d [COLS];
  logic [CW-1:0] cursor_q, cursor_d;
  logic          player_q, player_d;
  logic          busy_q, busy_d;
  logic          invalid_q, invalid_d;
  logic          win_a_q, win_a_d;
  logic          win_b_q, win_b_d;
  logic          full_q, full_d;
  logic [MW-1:0] count_q, count_d;
  logic [RW-1:0] last_row_q, last_row_d;
  logic [CW-1:0] last_col_q, last_col_d;
  logic          hit_acc_q, hit_acc_d;
  logic          run_hit;

  connect_n_run #(
    .ROWS    (ROWS),
    .COLS    (COLS),
    .WIN_LEN (WIN_LEN)
  ) u_run (
    .board      (board_q),
    .origin_row (last_row_q),
    .origin_col (last_col_q),
    .dir        (dir_q),
    .colour     (player_cell(player_q)),
    .hit        (run_hit)
  );

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    board_d    = board_q;
    height_d   = height_q;
    cursor_d   = cursor_q;
    player_d   = player_q;
    busy_d     = busy_q;
    invalid_d  = 1'b0;
    win_a_d    = win_a_q;
    win_b_d    = win_b_q;
    full_d     = full_q;
    count_d    = count_q;
    last_row_d = last_row_q;
    last_col_d = last_col_q;
    hit_acc_d  = hit_acc_q;

    if (new_game) begin
      state_d   = IDLE;
      dir_d     = H;
      board_d   = '0;
      height_d  = '{default: '0};
      cursor_d  = CurInit;
      player_d  = FirstP;
      busy_d    = 1'b0;
      win_a_d   = 1'b0;
      win_b_d   = 1'b0;
      full_d    = 1'b0;
      count_d   = '0;
      hit_acc_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (put) begin
            if (height_q[cursor_q] == RowsH) begin
              invalid_d = 1'b1;
            end else begin
              board_d[2*(int'(height_q[cursor_q])*int'(COLS) + int'(cursor_q)) +: 2] =
                player_cell(player_q);
              height_d[cursor_q] = height_q[cursor_q] + 1'b1;
              count_d    = count_q + 1'b1;
              last_row_d = RW'(height_q[cursor_q]);
              last_col_d = cursor_q;
              busy_d     = 1'b1;
              hit_acc_d  = 1'b0;
              dir_d      = H;
              state_d    = CHECK;
            end
          end else if (left && !right) begin
            cursor_d = (cursor_q == '0) ? ColMax : cursor_q - 1'b1;
          end else if (right && !left) begin
            cursor_d = (cursor_q == ColMax) ? '0 : cursor_q + 1'b1;
          end
        end
        CHECK: begin
          if (dir_q == D2) begin
            busy_d = 1'b0;
            // A win on the last free cell takes precedence over the full-board result.
            if (hit_acc_q || run_hit) begin
              state_d = DONE;
              if (player_q) win_b_d = 1'b1;
              else          win_a_d = 1'b1;
            end else if (count_q == CellsM) begin
              state_d = DONE;
              full_d  = 1'b1;
            end else begin
              state_d  = IDLE;
              player_d = ~player_q;
            end
          end else begin
            hit_acc_d = hit_acc_q | run_hit;
            case (dir_q)
              H:       dir_d = V;
              V:       dir_d = D1;
              default: dir_d = D2;
            endcase
          end
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      dir_q      <= H;
      board_q    <= '0;
      height_q   <= '{default: '0};
      cursor_q   <= CurInit;
      player_q   <= FirstP;
      busy_q     <= 1'b0;
      invalid_q  <= 1'b0;
      win_a_q    <= 1'b0;
      win_b_q    <= 1'b0;
      full_q     <= 1'b0;
      count_q    <= '0;
      last_row_q <= '0;
      last_col_q <= '0;
      hit_acc_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      board_q    <= board_d;
      height_q   <= height_d;
      cursor_q   <= cursor_d;
      player_q   <= player_d;
      busy_q     <= busy_d;
      invalid_q  <= invalid_d;
      win_a_q    <= win_a_d;
      win_b_q    <= win_b_d;
      full_q     <= full_d;
      count_q    <= count_d;
      last_row_q <= last_row_d;
      last_col_q <= last_col_d;
      hit_acc_q  <= hit_acc_d;
    end
  end

  assign board        = board_q;
  assign cursor       = cursor_q;
  assign player       = player_q;
  assign busy         = busy_q;
  assign invalid_move = invalid_q;
  assign win_a        = win_a_q;
  assign win_b        = win_b_q;
  assign full_panel   = full_q;
  assign move_count   = count_q;

endmodule

// File: tb/tb_connect_n_core.sv
// Scoreboard bench for connect_n_core: directed game scenarios plus random play vs a board model.
module tb_connect_n_core;

  localparam int ROWS = 6;
  localparam int COLS = 7;
  localparam int WIN  = 4;
  localparam int NB   = 2 * ROWS * COLS;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          left = 1'b0, right = 1'b0, put = 1'b0, new_game = 1'b0;
  logic [NB-1:0] board, board_b;
  logic [2:0]    cursor, cursor_b;
  logic          player, busy, invalid_move, win_a, win_b, full_panel;
  logic          player_b, busy_b, invalid_b, win_a_b, win_b_b, full_b;
  logic [5:0]    move_count, move_count_b;

  always #5 clk = ~clk;

  connect_n_core #(.ROWS(ROWS), .COLS(COLS), .WIN_LEN(WIN), .FIRST_PLAYER(0)) u_dut (
    .clk(clk), .rst(rst), .left(left), .right(right), .put(put), .new_game(new_game),
    .board(board), .cursor(cursor), .player(player), .busy(busy),
    .invalid_move(invalid_move), .win_a(win_a), .win_b(win_b), .full_panel(full_panel),
    .move_count(move_count)
  );

  connect_n_core #(.ROWS(ROWS), .COLS(COLS), .WIN_LEN(WIN), .FIRST_PLAYER(1)) u_dut_b (
    .clk(clk), .rst(rst), .left(left), .right(right), .put(put), .new_game(new_game),
    .board(board_b), .cursor(cursor_b), .player(player_b), .busy(busy_b),
    .invalid_move(invalid_b), .win_a(win_a_b), .win_b(win_b_b), .full_panel(full_b),
    .move_count(move_count_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: the board as a grid of cell codes plus game bookkeeping.
  logic [1:0] grid [ROWS][COLS];
  int         hgt [COLS];
  int         mcount, mcursor;
  logic       mplayer;
  bit         mdone, mwa, mwb, mfp;

  typedef struct {
    bit            inv;
    logic [NB-1:0] brd;
    logic          pl;
    logic          wa, wb, fp;
    int            cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  bit   skip_fall = 1'b0;
  logic prev_busy = 1'b0;

  int diag1 [10] = '{1, 0, 3, 2, 2, 1, 3, 2, 3, 3};
  int diag2 [10] = '{5, 6, 3, 4, 4, 5, 3, 4, 3, 3};
  int fill  [42] = '{0, 1, 0, 1, 0, 1, 1, 0, 1, 0, 1, 0,
                     2, 3, 2, 3, 2, 3, 3, 2, 3, 2, 3, 2,
                     4, 5, 4, 5, 4, 5, 6, 4, 6, 4, 6, 4, 5, 6, 5, 6, 5, 6};
  int winseq [7] = '{0, 6, 1, 6, 2, 6, 3};
  logic rl, rr, rp;

  function automatic void model_clear();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) grid[r][c] = 2'b00;
    for (int c = 0; c < COLS; c++) hgt[c] = 0;
    mcount  = 0;
    mcursor = COLS / 2;
    mplayer = 1'b0;
    mdone   = 1'b0;
    mwa     = 1'b0;
    mwb     = 1'b0;
    mfp     = 1'b0;
  endfunction

  function automatic logic [NB-1:0] model_board();
    logic [NB-1:0] v;
    v = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) v[2*(r*COLS+c) +: 2] = grid[r][c];
    return v;
  endfunction

  // Whole-board scan for any WIN-long line of one colour.
  function automatic bit has_run(input logic [1:0] colr);
    int drs [4];
    int dcs [4];
    int rr2, cc2;
    bit ok;
    drs = '{0, 1, 1, 1};
    dcs = '{1, 0, 1, -1};
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        for (int d = 0; d < 4; d++) begin
          ok = 1'b1;
          for (int k = 0; k < WIN; k++) begin
            rr2 = r + k * drs[d];
            cc2 = c + k * dcs[d];
            if (rr2 < 0 || rr2 >= ROWS || cc2 < 0 || cc2 >= COLS) ok = 1'b0;
            else if (grid[rr2][cc2] != colr) ok = 1'b0;
          end
          if (ok) return 1'b1;
        end
    return 1'b0;
  endfunction

  // kind: 0 dropped, 1 invalid, 2 accepted
  function automatic int model_put();
    exp_t       e;
    logic [1:0] colr;
    if (mdone) return 0;
    if (hgt[mcursor] == ROWS) begin
      e.inv = 1'b1;
    end else begin
      colr = mplayer ? 2'b10 : 2'b01;
      grid[hgt[mcursor]][mcursor] = colr;
      hgt[mcursor]++;
      mcount++;
      if (has_run(colr)) begin
        mdone = 1'b1;
        if (mplayer) mwb = 1'b1;
        else         mwa = 1'b1;
      end else if (mcount == ROWS * COLS) begin
        mdone = 1'b1;
        mfp   = 1'b1;
      end else begin
        mplayer = ~mplayer;
      end
      e.inv = 1'b0;
    end
    e.brd = model_board();
    e.pl  = mplayer;
    e.wa  = mwa;
    e.wb  = mwb;
    e.fp  = mfp;
    e.cnt = mcount;
    exp_q.push_back(e);
    return e.inv ? 1 : 2;
  endfunction

  function automatic void model_move(input logic l, input logic r);
    if (mdone) return;
    if (l && !r)      mcursor = (mcursor == 0) ? COLS - 1 : mcursor - 1;
    else if (r && !l) mcursor = (mcursor == COLS - 1) ? 0 : mcursor + 1;
  endfunction

  // Monitor: completed checks and invalid pulses are compared against queued expectations.
  always @(negedge clk) begin
    if (prev_busy && !busy) begin
      if (skip_fall) begin
        skip_fall = 1'b0;
      end else if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL mon_result: check completed with no expected result queued");
      end else begin
        mon_e = exp_q.pop_front();
        check("mon_kind_result", mon_e.inv, 1'b0);
        check("mon_board", board, mon_e.brd);
        check("mon_player", player, mon_e.pl);
        check("mon_win_a", win_a, mon_e.wa);
        check("mon_win_b", win_b, mon_e.wb);
        check("mon_full", full_panel, mon_e.fp);
        check("mon_count", move_count, mon_e.cnt);
      end
    end
    if (invalid_move) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL mon_invalid: invalid_move with no expectation queued");
      end else begin
        mon_e = exp_q.pop_front();
        check("mon_kind_invalid", mon_e.inv, 1'b1);
        check("mon_inv_board", board, mon_e.brd);
        check("mon_inv_player", player, mon_e.pl);
        check("mon_inv_count", move_count, mon_e.cnt);
      end
    end
    prev_busy = busy;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic move(input logic l, input logic r);
    left = l;
    right = r;
    tick();
    left = 1'b0;
    right = 1'b0;
    model_move(l, r);
    check("cursor", cursor, mcursor);
  endtask

  task automatic move_to(input int col);
    for (int i = 0; i < COLS && mcursor != col; i++) move(1'b0, 1'b1);
  endtask

  task automatic do_put(input logic l, input logic r);
    int   kind;
    logic pwa, pwb, pfp, ppl;
    pwa  = mwa;
    pwb  = mwb;
    pfp  = mfp;
    ppl  = mplayer;
    kind = model_put();
    left = l;
    right = r;
    put = 1'b1;
    tick();
    left = 1'b0;
    right = 1'b0;
    put = 1'b0;
    check("put_cursor_hold", cursor, mcursor);
    if (kind == 2) begin
      check("put_board_k", board, model_board());
      check("put_count_k", move_count, mcount);
      for (int i = 0; i < 4; i++) begin
        if (i > 0) tick();
        check("put_busy_high", busy, 1'b1);
        check("put_flags_held", {win_a, win_b, full_panel}, {pwa, pwb, pfp});
        check("put_player_held", player, ppl);
      end
      tick();
      check("put_busy_low", busy, 1'b0);
      check("put_flags_k4", {win_a, win_b, full_panel}, {mwa, mwb, mfp});
      check("put_player_k4", player, mplayer);
    end else if (kind == 1) begin
      check("inv_pulse", invalid_move, 1'b1);
      check("inv_busy", busy, 1'b0);
      tick();
      check("inv_pulse_end", invalid_move, 1'b0);
    end else begin
      check("drop_busy", busy, 1'b0);
      check("drop_invalid", invalid_move, 1'b0);
      check("drop_board", board, model_board());
    end
  endtask

  task automatic new_game_pulse();
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    model_clear();
    check("ng_board", board, '0);
    check("ng_count", move_count, 0);
    check("ng_player", player, 1'b0);
    check("ng_cursor", cursor, COLS / 2);
    check("ng_flags", {win_a, win_b, full_panel, busy}, 4'b0000);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_board"}, board, '0);
    check({tag, "_cursor"}, cursor, COLS / 2);
    check({tag, "_player"}, player, 1'b0);
    check({tag, "_outs"}, {busy, invalid_move, win_a, win_b, full_panel}, 5'b00000);
    check({tag, "_count"}, move_count, 0);
    check({tag, "_player_b"}, player_b, 1'b1);
    check({tag, "_board_b"}, board_b, '0);
  endtask

  initial begin
    model_clear();
    #12;
    check_reset_vals("reset");
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Cursor walk with wrap, then a first piece at (0,6).
    for (int i = 0; i < 4; i++) move(1'b1, 1'b0);
    check("cursor_wrap", cursor, 3'd6);
    do_put(1'b0, 1'b0);
    check("first_piece_a", board[13:12], 2'b01);
    check("first_piece_b", board_b[13:12], 2'b10);
    check("player_after_first", player, 1'b1);

    // Horizontal win for A; later inputs are ignored until new_game.
    new_game_pulse();
    for (int i = 0; i < 7; i++) begin
      move_to(winseq[i]);
      do_put(1'b0, 1'b0);
    end
    check("h_win_a", win_a, 1'b1);
    do_put(1'b0, 1'b0);
    move(1'b1, 1'b0);
    new_game_pulse();

    // Diagonal wins for B in both orientations.
    for (int i = 0; i < 10; i++) begin
      move_to(diag1[i]);
      do_put(1'b0, 1'b0);
    end
    check("diag1_win_b", {win_a, win_b}, 2'b01);
    new_game_pulse();
    for (int i = 0; i < 10; i++) begin
      move_to(diag2[i]);
      do_put(1'b0, 1'b0);
    end
    check("diag2_win_b", {win_a, win_b}, 2'b01);
    new_game_pulse();

    // Overfilled column.
    move_to(0);
    for (int i = 0; i < 7; i++) do_put(1'b0, 1'b0);
    check("colfull_count", move_count, 6);
    check("colfull_player", player, 1'b0);
    new_game_pulse();

    // Whole board without a line.
    for (int i = 0; i < 42; i++) begin
      move_to(fill[i]);
      do_put(1'b0, 1'b0);
    end
    check("fill_result", {win_a, win_b, full_panel}, 3'b001);
    new_game_pulse();

    // new_game with a simultaneous put during CHECK.
    move_to(2);
    put = 1'b1;
    tick();
    put = 1'b0;
    tick();
    check("abort_busy_mid", busy, 1'b1);
    skip_fall = 1'b1;
    new_game = 1'b1;
    put = 1'b1;
    tick();
    new_game = 1'b0;
    put = 1'b0;
    model_clear();
    check("abort_board", board, '0);
    check("abort_outs", {busy, win_a, win_b, full_panel}, 4'b0000);
    check("abort_count", move_count, 0);
    tick();
    check("abort_put_ignored", {busy, move_count}, 7'd0);

    // Asynchronous reset during CHECK.
    move_to(5);
    put = 1'b1;
    tick();
    put = 1'b0;
    tick();
    check("rst_busy_mid", busy, 1'b1);
    skip_fall = 1'b1;
    #2 rst = 1'b0;
    #1;
    model_clear();
    check_reset_vals("async_rst");
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Random play against the model.
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 29) == 0 || (mdone && $urandom_range(0, 3) == 0)) begin
        new_game_pulse();
      end else begin
        rl = 1'($urandom_range(0, 1));
        rr = 1'($urandom_range(0, 1));
        rp = ($urandom_range(0, 2) == 0);
        if (rp) do_put(rl, rr);
        else    move(rl, rr);
      end
    end

    tick();
    tick();
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
